// File: rtl/dsp_stream_mixer.sv
// dsp_stream_mixer
//   Takes 32-bit words from the HPS FIFO, extracts the top SAMPLE_WIDTH bits
//   as a two's complement sample and routes them to the left/right audio-out
//   FIFOs in mono-duplicate, stereo-interleaved (L word first) or mute mode.
//   Each channel gets a saturating unsigned gain (unity = 2^(GAIN_WIDTH-1)).
//   A thermometer peak-hold LED meter tracks output level with timed decay.
//
// Ports
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   mode               0 mono, 1 stereo, 2/3 mute
//   gain_l, gain_r     per-channel unsigned gain
//   valid_in_fifo,
//   ready_out_fifo,
//   stream_in          input word stream from the HPS FIFO
//   ready_in_audio,
//   valid_out_audioL/R,
//   stream_outL/R      registered sample pair towards the audio-out FIFOs
//   LEDS               peak meter, LED0 = lowest level
module dsp_stream_mixer #(
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned GAIN_WIDTH   = 8,
    parameter int unsigned LED_COUNT    = 10,
    parameter int unsigned DECAY_CYCLES = 5000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              mode,
    input  logic [GAIN_WIDTH-1:0]   gain_l,
    input  logic [GAIN_WIDTH-1:0]   gain_r,
    input  logic                    valid_in_fifo,
    output logic                    ready_out_fifo,
    input  logic [IN_WIDTH-1:0]     stream_in,
    input  logic                    ready_in_audio,
    output logic                    valid_out_audioL,
    output logic                    valid_out_audioR,
    output logic [SAMPLE_WIDTH-1:0] stream_outL,
    output logic [SAMPLE_WIDTH-1:0] stream_outR,
    output logic [LED_COUNT-1:0]    LEDS
);

    localparam int unsigned PROD_WIDTH = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int unsigned CNT_WIDTH  = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic signed [PROD_WIDTH-1:0] SCALED_MAX =
        {{(GAIN_WIDTH+2){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_WIDTH-1:0] SCALED_MIN =
        {{(GAIN_WIDTH+2){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic { PHASE_L, PHASE_R } phase_t;
    typedef enum logic [1:0] {
        MODE_MONO     = 2'd0,
        MODE_STEREO   = 2'd1,
        MODE_MUTE     = 2'd2,
        MODE_MUTE_ALT = 2'd3
    } mode_t;

    // Signed sample times unsigned gain, scaled back by the unity weight with
    // an arithmetic shift (floor), then clamped to the sample range.
    function automatic logic [SAMPLE_WIDTH-1:0] applyGain(
        input logic [SAMPLE_WIDTH-1:0] sample,
        input logic [GAIN_WIDTH-1:0]   gain
    );
        logic signed [PROD_WIDTH-1:0] sampleExt;
        logic signed [PROD_WIDTH-1:0] gainExt;
        logic signed [PROD_WIDTH-1:0] product;
        logic signed [PROD_WIDTH-1:0] scaled;
        sampleExt = {{(GAIN_WIDTH+1){sample[SAMPLE_WIDTH-1]}}, sample};
        gainExt   = {{(SAMPLE_WIDTH+1){1'b0}}, gain};
        product   = sampleExt * gainExt;
        scaled    = product >>> (GAIN_WIDTH - 1);
        if (scaled > SCALED_MAX) return SAMPLE_MAX;
        if (scaled < SCALED_MIN) return SAMPLE_MIN;
        return scaled[SAMPLE_WIDTH-1:0];
    endfunction

    // |x| with the most negative value clamped to the positive maximum.
    function automatic logic [SAMPLE_WIDTH-1:0] magnitude(input logic [SAMPLE_WIDTH-1:0] x);
        if (!x[SAMPLE_WIDTH-1]) return x;
        if (x == SAMPLE_MIN) return SAMPLE_MAX;
        return '0 - x;
    endfunction

    phase_t                  phase, phaseNext;
    logic [SAMPLE_WIDTH-1:0] holdSample, holdSampleNext;
    logic                    validOut, validOutNext;
    logic [SAMPLE_WIDTH-1:0] outL, outLNext, outR, outRNext;
    logic [LED_COUNT-1:0]    leds, ledsNext;
    logic [CNT_WIDTH-1:0]    decayCnt, decayCntNext;
    logic [1:0]              prevMode;

    mode_t                   modeSel;
    logic                    modeChanged;
    phase_t                  effPhase;
    logic                    accept;
    logic                    consume;
    logic                    loadPair;
    logic                    decayWrap;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic [SAMPLE_WIDTH-1:0] pairL, pairR;
    logic [SAMPLE_WIDTH-1:0] magL, magR, mag;
    logic [LED_COUNT-1:0]    bar;

    assign sample         = stream_in[IN_WIDTH-1 -: SAMPLE_WIDTH];
    assign ready_out_fifo = !validOut || ready_in_audio;

    generate
        if (IN_WIDTH > SAMPLE_WIDTH) begin : gUnusedLow
            logic unusedLowBits;
            assign unusedLowBits = ^stream_in[IN_WIDTH-SAMPLE_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        phaseNext      = phase;
        holdSampleNext = holdSample;
        validOutNext   = validOut;
        outLNext       = outL;
        outRNext       = outR;
        ledsNext       = leds;
        decayCntNext   = decayCnt;
        loadPair       = 1'b0;
        pairL          = '0;
        pairR          = '0;
        magL           = '0;
        magR           = '0;
        mag            = '0;
        bar            = '0;

        modeSel     = mode_t'(mode);
        modeChanged = (mode != prevMode);
        accept      = valid_in_fifo && ready_out_fifo;
        consume     = validOut && ready_in_audio;
        // A word accepted in the mode-change cycle already sees phase L, so it
        // starts a fresh stereo pair instead of completing a stale one.
        effPhase    = modeChanged ? PHASE_L : phase;

        if (modeChanged) begin
            phaseNext      = PHASE_L;
            holdSampleNext = '0;
        end

        if (accept) begin
            case (modeSel)
                MODE_MONO: begin
                    loadPair = 1'b1;
                    pairL    = applyGain(sample, gain_l);
                    pairR    = applyGain(sample, gain_r);
                end
                MODE_STEREO: begin
                    if (effPhase == PHASE_L) begin
                        holdSampleNext = sample;
                        phaseNext      = PHASE_R;
                    end else begin
                        loadPair  = 1'b1;
                        pairL     = applyGain(holdSample, gain_l);
                        pairR     = applyGain(sample, gain_r);
                        phaseNext = PHASE_L;
                    end
                end
                default: begin
                    loadPair = 1'b1;
                end
            endcase
        end

        // Loading takes priority over consuming so back-to-back pairs leave no bubble.
        if (loadPair) begin
            validOutNext = 1'b1;
            outLNext     = pairL;
            outRNext     = pairR;
        end else if (consume) begin
            validOutNext = 1'b0;
        end

        decayWrap    = (decayCnt == CNT_WIDTH'(DECAY_CYCLES - 1));
        decayCntNext = decayWrap ? '0 : decayCnt + CNT_WIDTH'(1);

        magL = magnitude(pairL);
        magR = magnitude(pairR);
        mag  = (magL > magR) ? magL : magR;
        for (int unsigned k = 0; k < LED_COUNT; k++) begin
            bar[k] = (mag >= (SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1 - LED_COUNT + k)));
        end

        if (decayWrap) ledsNext = leds >> 1;
        if (loadPair)  ledsNext = ledsNext | bar;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= PHASE_L;
            holdSample <= '0;
            validOut   <= 1'b0;
            outL       <= '0;
            outR       <= '0;
            leds       <= '0;
            decayCnt   <= '0;
            prevMode   <= '0;
        end else begin
            phase      <= phaseNext;
            holdSample <= holdSampleNext;
            validOut   <= validOutNext;
            outL       <= outLNext;
            outR       <= outRNext;
            leds       <= ledsNext;
            decayCnt   <= decayCntNext;
            prevMode   <= mode;
        end
    end

    assign valid_out_audioL = validOut;
    assign valid_out_audioR = validOut;
    assign stream_outL      = outL;
    assign stream_outR      = outR;
    assign LEDS             = leds;

endmodule
